// File: rtl/ysyx_22040759_mem_pkg.sv
// ysyx_22040759_mem_pkg: shared bus widths, load encodings, FSM states and stage-bus layout.
package ysyx_22040759_mem_pkg;
  localparam int ES_TO_MS_BUS_W = 205;
  localparam int MS_TO_WS_BUS_W = 200;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT_R = 2'd2, S_DONE = 2'd3} state_t;
  typedef struct packed {
    logic [63:0] src2;
    logic        mem_wen;
    logic        mem_ren;
    logic [2:0]  func3;
    logic [1:0]  wreg_sel;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] alu_result;
    logic [63:0] pc;
  } es_bus_t;
  function automatic logic [7:0] store_mask(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] base;
    base = sz == 2'b00 ? 8'h01 : sz == 2'b01 ? 8'h03 : sz == 2'b10 ? 8'h0F : 8'hFF;
    return base << off;
  endfunction
endpackage

// File: rtl/ysyx_22040759_mem_lsu_ext.sv
// ysyx_22040759_lsu_ext: aligns a loaded doubleword by byte offset and extends it per func3.
module ysyx_22040759_lsu_ext
  import ysyx_22040759_mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  func3,
  output logic [63:0] result
);
  logic [63:0] sh;
  assign sh = rdata >> {off, 3'b000};
  always_comb begin
    result = func3 == F3_LB  ? {{56{sh[7]}}, sh[7:0]} :
             func3 == F3_LH  ? {{48{sh[15]}}, sh[15:0]} :
             func3 == F3_LW  ? {{32{sh[31]}}, sh[31:0]} :
             func3 == F3_LD  ? sh :
             func3 == F3_LBU ? {56'd0, sh[7:0]} :
             func3 == F3_LHU ? {48'd0, sh[15:0]} :
             func3 == F3_LWU ? {32'd0, sh[31:0]} : 64'd0;
  end
endmodule

// File: rtl/ysyx_22040759_mem.sv
// ysyx_22040759_mem: MEM pipeline stage with a req/gnt/rvalid data-memory handshake.
module ysyx_22040759_mem
  import ysyx_22040759_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
  output logic                      ms_allowin,
  input  logic                      ws_allowin,
  output logic                      ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
  output logic                      dmem_req,
  output logic                      dmem_wr,
  output logic [63:0]               dmem_addr,
  output logic [63:0]               dmem_wdata,
  output logic [7:0]                dmem_wmask,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [63:0]               dmem_rdata
);
  es_bus_t     r;
  state_t      state, state_n;
  logic        ms_valid, is_mem, ms_ready_go, capture;
  logic [2:0]  off;
  logic [63:0] mem_res, ext_res;
  assign off            = r.alu_result[2:0];
  assign is_mem         = r.mem_ren | r.mem_wen;
  assign ms_ready_go    = !is_mem || state == S_DONE;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign dmem_req       = state == S_REQ;
  assign dmem_wr        = dmem_req && r.mem_wen;
  assign dmem_addr      = {r.alu_result[63:3], 3'b000};
  assign dmem_wdata     = r.src2 << {off, 3'b000};
  assign dmem_wmask     = store_mask(r.func3[1:0], off);
  // A grant with rvalid in the same cycle completes a load without visiting WAIT_R.
  assign capture = (state == S_WAIT_R && dmem_rvalid) ||
                   (state == S_REQ && dmem_gnt && dmem_rvalid && !r.mem_wen);
  assign ms_to_ws_bus = {r.wreg_sel, r.reg_wen, r.rd, r.mem_ren ? mem_res : 64'd0, r.alu_result, r.pc};
  ysyx_22040759_lsu_ext u_ext (
    .rdata (dmem_rdata),
    .off   (off),
    .func3 (r.func3),
    .result(ext_res)
  );
  always_comb begin
    state_n = state == S_IDLE   ? (ms_valid && is_mem ? S_REQ : S_IDLE) :
              state == S_REQ    ? (!dmem_gnt ? S_REQ : (r.mem_wen || dmem_rvalid) ? S_DONE : S_WAIT_R) :
              state == S_WAIT_R ? (dmem_rvalid ? S_DONE : S_WAIT_R) :
                                  (ms_to_ws_valid && ws_allowin ? S_IDLE : S_DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_valid <= 1'b0;
      state    <= S_IDLE;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      state <= state_n;
    end
  end
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) r <= es_to_ms_bus;
    if (capture) mem_res <= ext_res;
  end
endmodule

// File: tb/tb_ysyx_22040759_mem.sv
// tb_ysyx_22040759_mem: randomized stimulus against a byte-level memory-stage reference model.
module tb_ysyx_22040759_mem;
  logic         clk = 1'b0, rst;
  logic         es_to_ms_valid, ms_allowin, ws_allowin, ms_to_ws_valid;
  logic [204:0] es_to_ms_bus;
  logic [199:0] ms_to_ws_bus;
  logic         dmem_req, dmem_wr, dmem_gnt, dmem_rvalid;
  logic [63:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]   dmem_wmask;
  always #5 clk = ~clk;
  ysyx_22040759_mem dut (
    .clk(clk), .rst(rst), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic int acc_size(input logic [1:0] sz);
    return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : sz == 2'b10 ? 4 : 8;
  endfunction
  // Bytes past the end of the doubleword read as zero before extension.
  function automatic logic [63:0] exp_load(input logic [63:0] w, input int off, input logic [2:0] f3);
    logic [63:0] v;
    int n;
    n = acc_size(f3[1:0]);
    v = '0;
    if (f3 == 3'b111) return '0;
    for (int i = 0; i < n; i++) if (off + i < 8) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction
  function automatic logic [7:0] exp_mask(input int off, input logic [1:0] sz);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < acc_size(sz); i++) if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction
  typedef struct {
    logic [199:0] bus;
    int           kind;
    logic [63:0]  addr;
    logic [7:0]   mask;
    logic [63:0]  wdata;
  } exp_t;
  exp_t        q[$];
  logic [63:0] ref_mem[8];
  logic [63:0] resp_mem[8];
  initial begin
    logic         after_rst, hold_v;
    logic [199:0] hold_bus;
    logic [63:0]  src2, alu, pc, mr;
    logic [2:0]   f3;
    exp_t         e;
    after_rst = 1'b0;
    hold_v    = 1'b0;
    hold_bus  = '0;
    chk("model_lh_off6", exp_load(64'h8001_0000_0000_0000, 6, 3'b001), 64'hFFFF_FFFF_FFFF_8001);
    chk("model_lbu_ff", exp_load(64'h1234_5678_9ABC_DEFF, 0, 3'b100), 64'hFF);
    chk("model_lb_ff", exp_load(64'h1234_5678_9ABC_DEFF, 0, 3'b000), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_lw_cross", exp_load(64'hFFFF_0000_0000_0000, 6, 3'b010), 64'h0000_FFFF);
    chk("model_f3_111", exp_load(64'hFFFF_FFFF_FFFF_FFFF, 0, 3'b111), 64'h0);
    chk("model_sb_mask", exp_mask(3, 2'b00), 8'h08);
    chk("model_sd_mask_cross", exp_mask(3, 2'b11), 8'hF8);
    forever begin
      @(negedge clk);
      if (after_rst) begin
        chk("rst_valid", ms_to_ws_valid, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_wr", dmem_wr, 1'b0);
        chk("rst_allowin", ms_allowin, 1'b1);
      end
      after_rst = rst;
      if (rst) begin
        q.delete();
        hold_v = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = resp_mem[i];
        continue;
      end
      if (hold_v) begin
        chk("stall_valid", ms_to_ws_valid, 1'b1);
        chk("stall_bus", ms_to_ws_bus, hold_bus);
      end
      if (ms_to_ws_valid) begin
        chk("out_pending", q.size() > 0, 1'b1);
        if (q.size() > 0) chk("out_bus", ms_to_ws_bus, q[0].bus);
        chk("no_req_when_done", dmem_req, 1'b0);
      end
      if (dmem_req) begin
        chk("req_pending", q.size() > 0 && q[0].kind != 0, 1'b1);
        if (q.size() > 0) begin
          chk("req_addr", dmem_addr, q[0].addr);
          chk("req_wr", dmem_wr, q[0].kind == 2);
          if (q[0].kind == 2) begin
            chk("req_mask", dmem_wmask, q[0].mask);
            chk("req_wdata", dmem_wdata, q[0].wdata);
          end
        end
      end
      if (q.size() > 0 && !ms_to_ws_valid) chk("busy_allowin", ms_allowin, 1'b0);
      if (q.size() > 0 && q[0].kind == 0) chk("alu_zero_latency", ms_to_ws_valid, 1'b1);
      if (ms_to_ws_valid && ws_allowin && q.size() > 0) void'(q.pop_front());
      hold_v   = ms_to_ws_valid && !ws_allowin;
      hold_bus = ms_to_ws_bus;
      if (es_to_ms_valid && ms_allowin) begin
        src2 = es_to_ms_bus[204:141];
        f3   = es_to_ms_bus[138:136];
        alu  = es_to_ms_bus[127:64];
        pc   = es_to_ms_bus[63:0];
        e.kind  = es_to_ms_bus[139] ? 1 : es_to_ms_bus[140] ? 2 : 0;
        e.addr  = {alu[63:3], 3'b000};
        e.mask  = exp_mask(int'(alu[2:0]), f3[1:0]);
        e.wdata = src2 << (8 * int'(alu[2:0]));
        mr = e.kind == 1 ? exp_load(ref_mem[alu[5:3]], int'(alu[2:0]), f3) : 64'd0;
        if (e.kind == 2)
          for (int i = 0; i < 8; i++)
            if (e.mask[i]) ref_mem[alu[5:3]][8*i +: 8] = src2[8*(i-int'(alu[2:0])) +: 8];
        e.bus = {es_to_ms_bus[135:128], mr, alu, pc};
        q.push_back(e);
      end
    end
  end
  initial begin
    int          pend, kind;
    logic [63:0] pdata, alu;
    logic [2:0]  f3, idx;
    pend = 0;
    pdata = '0;
    rst = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    for (int i = 0; i < 8; i++) resp_mem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata = {$urandom, $urandom};
      if (pend > 0) begin
        if (pend == 1) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = pdata;
          pend = 0;
        end else begin
          pend--;
          if ($urandom % 15 == 0) rst = 1'b1;
        end
      end else if (dmem_req && $urandom % 3 == 0) begin
        dmem_gnt = 1'b1;
        idx = dmem_addr[5:3];
        if (dmem_wr) begin
          for (int i = 0; i < 8; i++) if (dmem_wmask[i]) resp_mem[idx][8*i +: 8] = dmem_wdata[8*i +: 8];
        end else begin
          pdata = resp_mem[idx];
          pend = $urandom % 4;
          if (pend == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = pdata;
          end else pend++;
        end
      end else begin
        dmem_gnt = !dmem_req && $urandom % 6 == 0;
        dmem_rvalid = $urandom % 6 == 0;
      end
      if (!rst && $urandom % 300 == 0) rst = 1'b1;
      kind = $urandom % 3;
      f3 = kind == 2 ? 3'($urandom % 4) : 3'($urandom % 8);
      alu = kind == 0 ? {$urandom, $urandom} : 64'h8000_0000 + 64'($urandom_range(0, 63));
      es_to_ms_valid = $urandom % 2 == 0;
      es_to_ms_bus = {{$urandom, $urandom}, kind == 2, kind == 1, f3, 2'($urandom), 1'($urandom),
                      5'($urandom), alu, {$urandom, $urandom}};
      ws_allowin = $urandom % 4 != 0;
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
